// File: rtl/tlp_tag_tracker.sv
// tlp_tag_tracker: allocates PCIe non-posted tags, tracks completion byte counts and ages,
// and reports completion done/error and timeouts.
module tlp_tag_tracker #(
  parameter int SUPPORT_10BIT_TAG = 0,
  parameter int NUM_TAGS          = 32,
  parameter int TICK_CYCLES       = 1024,
  parameter int TIMEOUT_TICKS     = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  input  logic [9:0]                  alloc_len,
  output logic                        alloc_gnt,
  output logic [9:0]                  alloc_tag,
  input  logic                        cpl_valid,
  input  logic [9:0]                  cpl_tag,
  input  logic [9:0]                  cpl_len,
  output logic                        cpl_done,
  output logic                        cpl_err,
  output logic                        timeout_valid,
  output logic [9:0]                  timeout_tag,
  output logic [$clog2(NUM_TAGS):0]   outstanding_cnt,
  output logic                        full,
  output logic                        empty
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int CW = TW + 1;
  localparam int PW = $clog2(TICK_CYCLES);
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [10:0]         rem_q [NUM_TAGS];
  logic [10:0]         rem_d [NUM_TAGS];
  logic [3:0]          age_q [NUM_TAGS];
  logic [3:0]          age_d [NUM_TAGS];
  logic [PW-1:0]       pre_q, pre_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d, err_q, err_d, tv_q, tv_d;
  logic [9:0]          tt_q, tt_d;
  logic [TW-1:0]       free_idx, to_idx, cpl_idx;
  logic                to_hit, tick, cpl_ok, rel_cpl;
  logic [10:0]         clen, crem;

  assign full            = cnt_q == CW'(NUM_TAGS);
  assign empty           = cnt_q == '0;
  assign alloc_gnt       = alloc_req && !full && !rst;
  assign alloc_tag       = 10'(free_idx);
  assign outstanding_cnt = cnt_q;
  assign cpl_done        = done_q;
  assign cpl_err         = err_q;
  assign timeout_valid   = tv_q;
  assign timeout_tag     = tt_q;
  assign tick            = pre_q == PW'(TICK_CYCLES - 1);
  assign cpl_idx         = cpl_tag[TW-1:0];
  assign clen            = cpl_len == '0 ? 11'd1024 : {1'b0, cpl_len};
  assign crem            = rem_q[cpl_idx];

  always_comb begin
    free_idx = '0;
    to_idx   = '0;
    to_hit   = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = TW'(i);
      if (busy_q[i] && age_q[i] == 4'(TIMEOUT_TICKS)) begin
        to_idx = TW'(i);
        to_hit = 1'b1;
      end
    end
  end

  // A completion racing the timeout of its own tag is treated as unexpected.
  assign cpl_ok  = cpl_valid && ({1'b0, cpl_tag} < 11'(NUM_TAGS)) &&
                   (SUPPORT_10BIT_TAG != 0 || cpl_tag[9:8] == 2'b00) &&
                   busy_q[cpl_idx] && !(to_hit && to_idx == cpl_idx);
  assign rel_cpl = cpl_ok && clen >= crem;

  always_comb begin
    busy_d = busy_q;
    rem_d  = rem_q;
    age_d  = age_q;
    pre_d  = tick ? '0 : pre_q + 1'b1;
    for (int i = 0; i < NUM_TAGS; i++)
      if (tick && busy_q[i] && age_q[i] < 4'(TIMEOUT_TICKS)) age_d[i] = age_q[i] + 4'd1;
    if (to_hit) busy_d[to_idx] = 1'b0;
    if (cpl_ok && clen < crem) begin
      rem_d[cpl_idx] = crem - clen;
      age_d[cpl_idx] = '0;
    end
    if (rel_cpl) busy_d[cpl_idx] = 1'b0;
    if (alloc_gnt) begin
      busy_d[free_idx] = 1'b1;
      rem_d[free_idx]  = alloc_len == '0 ? 11'd1024 : {1'b0, alloc_len};
      age_d[free_idx]  = '0;
    end
    done_d = cpl_ok && clen == crem;
    err_d  = cpl_valid && (!cpl_ok || clen > crem);
    tv_d   = to_hit;
    tt_d   = to_hit ? 10'(to_idx) : tt_q;
    cnt_d  = cnt_q + CW'(alloc_gnt) - CW'(rel_cpl) - CW'(to_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        rem_q[i] <= '0;
        age_q[i] <= '0;
      end
      pre_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tv_q   <= 1'b0;
      tt_q   <= '0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      age_q  <= age_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      tv_q   <= tv_d;
      tt_q   <= tt_d;
    end
  end
endmodule

// File: tb/tb_tlp_tag_tracker.sv
// tb_tlp_tag_tracker: vector table plus directed sequences for allocation, completion,
// timeout and reset behaviour.
module tb_tlp_tag_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0, cpl_valid = 1'b0;
  logic [9:0] alloc_len = '0, cpl_tag = '0, cpl_len = '0;
  logic       a_gnt, a_done, a_err, a_tv, a_full, a_empty;
  logic [9:0] a_tag, a_ttag;
  logic [5:0] a_cnt;
  logic       b_gnt, b_done, b_err, b_tv, b_full, b_empty;
  logic [9:0] b_tag, b_ttag;
  logic [5:0] b_cnt;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    bit ar; int al; bit cv; int ct; int cl;
    bit gnt; int tag; bit done; bit err; int cnt;
  } vec_t;
  typedef struct { bit done; bit err; int cnt; } exp_t;
  exp_t sb[$];
  vec_t vt[12];

  always #5 clk = ~clk;

  tlp_tag_tracker u_a (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_len(alloc_len),
    .alloc_gnt(a_gnt), .alloc_tag(a_tag), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .cpl_len(cpl_len), .cpl_done(a_done), .cpl_err(a_err), .timeout_valid(a_tv),
    .timeout_tag(a_ttag), .outstanding_cnt(a_cnt), .full(a_full), .empty(a_empty));

  tlp_tag_tracker #(.TICK_CYCLES(4), .TIMEOUT_TICKS(2)) u_b (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_len(alloc_len),
    .alloc_gnt(b_gnt), .alloc_tag(b_tag), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .cpl_len(cpl_len), .cpl_done(b_done), .cpl_err(b_err), .timeout_valid(b_tv),
    .timeout_tag(b_ttag), .outstanding_cnt(b_cnt), .full(b_full), .empty(b_empty));

  function automatic vec_t mk(bit ar, int al, bit cv, int ct, int cl,
                              bit gnt, int tag, bit done, bit err, int cnt);
    vec_t v;
    v.ar = ar; v.al = al; v.cv = cv; v.ct = ct; v.cl = cl;
    v.gnt = gnt; v.tag = tag; v.done = done; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ar, input int al, input bit cv, input int ct, input int cl);
    alloc_req = ar;
    alloc_len = 10'(al);
    cpl_valid = cv;
    cpl_tag   = 10'(ct);
    cpl_len   = 10'(cl);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   k;
    vt[0]  = mk(1, 8, 0, 0, 0,       1, 0, 0, 0, 1);
    vt[1]  = mk(1, 2, 0, 0, 0,       1, 1, 0, 0, 2);
    vt[2]  = mk(0, 0, 1, 0, 4,       0, 0, 0, 0, 2);
    vt[3]  = mk(1, 1, 1, 0, 4,       1, 2, 1, 0, 2);
    vt[4]  = mk(1, 1, 0, 0, 0,       1, 0, 0, 0, 3);
    vt[5]  = mk(0, 0, 1, 1, 3,       0, 0, 0, 1, 2);
    vt[6]  = mk(0, 0, 1, 1, 1,       0, 0, 0, 1, 2);
    vt[7]  = mk(0, 0, 1, 'h100, 1,   0, 0, 0, 1, 2);
    vt[8]  = mk(0, 0, 1, 2, 0,       0, 0, 0, 1, 1);
    vt[9]  = mk(0, 0, 1, 0, 1,       0, 0, 1, 0, 0);
    vt[10] = mk(1, 0, 0, 0, 0,       1, 0, 0, 0, 1);
    vt[11] = mk(0, 0, 1, 0, 0,       0, 0, 1, 0, 0);

    do_reset;
    chk("reset_cnt", a_cnt, 0);
    chk("reset_empty", a_empty, 1);
    chk("reset_full", a_full, 0);
    chk("reset_tv", a_tv, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].ar, vt[i].al, vt[i].cv, vt[i].ct, vt[i].cl);
      #1;
      if (vt[i].ar) begin
        chk($sformatf("vec%0d_gnt", i), a_gnt, vt[i].gnt);
        chk($sformatf("vec%0d_tag", i), a_tag, vt[i].tag);
      end
      e.done = vt[i].done; e.err = vt[i].err; e.cnt = vt[i].cnt;
      sb.push_back(e);
      step;
      e = sb.pop_front();
      chk($sformatf("vec%0d_done", i), a_done, e.done);
      chk($sformatf("vec%0d_err", i), a_err, e.err);
      chk($sformatf("vec%0d_cnt", i), a_cnt, e.cnt);
    end
    drive(0, 0, 0, 0, 0);
    step;

    do_reset;
    for (int i = 0; i < 32; i++) begin
      drive(1, 8, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d_gnt", i), a_gnt, 1);
      chk($sformatf("fill%0d_tag", i), a_tag, i);
      step;
    end
    chk("fill_full", a_full, 1);
    chk("fill_cnt", a_cnt, 32);
    chk("fill_empty", a_empty, 0);
    #1 chk("req33_gnt", a_gnt, 0);
    step;
    chk("req33_cnt", a_cnt, 32);
    drive(0, 0, 1, 3, 4);
    step;
    chk("t3_part_done", a_done, 0);
    chk("t3_part_err", a_err, 0);
    chk("t3_part_cnt", a_cnt, 32);
    drive(0, 0, 1, 3, 4);
    step;
    chk("t3_final_done", a_done, 1);
    chk("t3_final_cnt", a_cnt, 31);
    chk("t3_final_full", a_full, 0);
    drive(1, 5, 0, 0, 0);
    #1;
    chk("t3_regrant_gnt", a_gnt, 1);
    chk("t3_regrant_tag", a_tag, 3);
    step;
    chk("t3_once_done", a_done, 0);
    chk("t3_regrant_cnt", a_cnt, 32);

    drive(0, 0, 1, 'h105, 8);
    step;
    chk("hi_tag_busy_err", a_err, 1);
    chk("hi_tag_busy_done", a_done, 0);
    chk("hi_tag_busy_cnt", a_cnt, 32);
    drive(0, 0, 1, 5, 8);
    step;
    chk("t5_done", a_done, 1);
    chk("t5_cnt", a_cnt, 31);
    drive(0, 0, 1, 'h105, 8);
    step;
    chk("hi_tag_free_err", a_err, 1);
    chk("hi_tag_free_cnt", a_cnt, 31);
    drive(0, 0, 1, 5, 8);
    step;
    chk("free_tag_err", a_err, 1);
    chk("free_tag_done", a_done, 0);
    chk("free_tag_cnt", a_cnt, 31);

    do_reset;
    for (int i = 0; i < 10; i++) begin
      drive(1, 4, 0, 0, 0);
      step;
    end
    chk("busy10_cnt", a_cnt, 10);
    drive(1, 4, 1, 2, 4);
    #3 rst = 1'b1;
    #1;
    chk("rst_cnt", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_tv", a_tv, 0);
    chk("rst_ttag", a_ttag, 0);
    drive(1, 4, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_gnt", a_gnt, 1);
    chk("post_rst_tag", a_tag, 0);
    step;
    chk("post_rst_cnt", a_cnt, 1);

    do_reset;
    drive(1, 4, 0, 0, 0);
    step;
    drive(1, 4, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0);
    chk("to_cnt_before", b_cnt, 2);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step;
      if (b_tv) begin
        k = i;
        break;
      end
    end
    chk("to_first_latency", k, 7);
    chk("to_first_tag", b_ttag, 0);
    step;
    chk("to_second_valid", b_tv, 1);
    chk("to_second_tag", b_ttag, 1);
    chk("to_second_cnt", b_cnt, 0);
    step;
    chk("to_idle_valid", b_tv, 0);

    do_reset;
    drive(1, 4, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0);
    repeat (7) step;
    chk("race_pre_tv", b_tv, 0);
    drive(0, 0, 1, 0, 4);
    step;
    chk("race_tv", b_tv, 1);
    chk("race_ttag", b_ttag, 0);
    chk("race_err", b_err, 1);
    chk("race_done", b_done, 0);
    chk("race_cnt", b_cnt, 0);
    drive(0, 0, 0, 0, 0);
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
